alu: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/alu_if.sv | 27 ++
 rtl/alu_addsub.sv | 29 ++
 rtl/alu.sv | 78 +++++++
 tb/tb_alu.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage ALU and its neighbours.
//   DATA_W   : machine datapath width.
//   alu_op_t : 3-bit ALU operation code. The control unit's ALU Op field maps
//              straight onto these encodings.
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the EX-stage operand muxes and the ALU.
//   a, b, op                           : operands and operation (master -> slave)
//   result, zero, carry, overflow      : registered outputs (slave -> master)
// The master modport belongs to whoever supplies operands; the ALU takes slave.
interface alu_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_t          op;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output a, b, op,
    input  result, zero, carry, overflow
  );

  modport slave (
    input  a, b, op,
    output result, zero, carry, overflow
  );
endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder with optional B inversion and carry-in, shared
// by ADD, SUB and SLT.
//   a, b     : operands
//   sub      : 1 -> compute a + ~b + 1, 0 -> a + b
//   sum      : WIDTH-bit wrapped result
//   carry    : carry-out of the MSB (for SUB this is "no borrow")
//   overflow : signed overflow of the operation actually performed
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    // Adding same-signed values that yield the other sign overflowed. Using the
    // inverted B covers SUB too: a, b of different sign means a, ~b match.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// 16-bit EX-stage ALU with single-cycle registered outputs.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (result=0, zero=1, carry=0, overflow=0)
//   bus   : alu_if slave - a, b, op in; result, zero, carry, overflow out
// Every cycle the inputs are captured and the outputs reflect them after the
// edge. zero comes from the same next-result value as result, so the MEM-stage
// BNE logic always sees a consistent pair.
module alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_overflow;
  logic             as_sub;

  logic [WIDTH-1:0] result_next;
  logic             zero_next;
  logic             carry_next;
  logic             overflow_next;
  logic [3:0]       shamt;

  // Only ADD adds; SUB and SLT both need a - b.
  assign as_sub = (bus.op != ALU_ADD);
  assign shamt  = bus.b[3:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (bus.a),
    .b        (bus.b),
    .sub      (as_sub),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_overflow)
  );

  always_comb begin
    result_next   = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    unique case (bus.op)
      ALU_ADD, ALU_SUB: begin
        result_next   = as_sum;
        carry_next    = as_carry;
        overflow_next = as_overflow;
      end
      ALU_AND: result_next = bus.a & bus.b;
      ALU_OR:  result_next = bus.a | bus.b;
      ALU_XOR: result_next = bus.a ^ bus.b;
      // Sign of the difference alone is wrong when a - b overflows.
      ALU_SLT: result_next = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_overflow};
      ALU_SLL: result_next = bus.a << shamt;
      ALU_SRL: result_next = bus.a >> shamt;
      default: result_next = '0;
    endcase
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result   <= '0;
      bus.zero     <= 1'b1;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.result   <= result_next;
      bus.zero     <= zero_next;
      bus.carry    <= carry_next;
      bus.overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand-written reset and
// timing sequences, and a back-to-back random sweep against a reference model.
module tb_alu;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_if #(.WIDTH(16)) bus ();

  alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] r, input logic z,
                            input logic c, input logic v);
    check({tag, ".result"},   {16'h0, bus.result}, {16'h0, r});
    check({tag, ".zero"},     {31'h0, bus.zero},     {31'h0, z});
    check({tag, ".carry"},    {31'h0, bus.carry},    {31'h0, c});
    check({tag, ".overflow"}, {31'h0, bus.overflow}, {31'h0, v});
  endtask

  // Reference model using integer arithmetic rather than an adder structure.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       output logic [15:0] r, output logic z, output logic c, output logic v);
    int sa, sb, sr;
    int ua, ub, ur;
    int p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'({16'h0, a});
    ub = int'({16'h0, b});
    p  = 1 << b[3:0];
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        ur = ua + ub; r = ur[15:0]; c = (ur > 65535);
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        ur = ua - ub; r = ur[15:0]; c = (ua >= ub);
        sr = sa - sb; v = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 16'd1 : 16'd0;
      3'd6: begin ur = ua * p; r = ur[15:0]; end
      default: begin ur = ua / p; r = ur[15:0]; end
    endcase
    z = (r == 16'h0);
  endtask

  vec_t vecs[17];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] er;
    logic        ez, ec, ev;
    logic [15:0] pa, pb;
    logic [2:0]  pop;

    total = 0;
    bad   = 0;

    //          a         b         op    result   z     c     v
    vecs[0]  = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{16'h0005, 16'h0005, 3'd1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'h0003, 16'h0005, 3'd1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 3'd5, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h8000, 3'd5, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1234, 3'd5, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'hF0F0, 16'h0FF0, 3'd3, 16'hFFF0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'hF0F0, 16'h0FF0, 3'd4, 16'hFF00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h8001, 16'h0014, 3'd6, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h8001, 16'h0014, 3'd7, 16'h0800, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'hABCD, 16'hFFF0, 3'd6, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'hABCD, 16'h0010, 3'd7, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{16'h8000, 16'h000F, 3'd7, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{16'h8000, 16'h8000, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1};

    // Reset asserted: outputs must take reset values without any clock edge.
    rst_n  = 1'b1;
    bus.a  = 16'h1234;
    bus.b  = 16'h0001;
    bus.op = ALU_ADD;
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn reset-initial a=%h op=ADD", bus.a);
    check_outs("reset_async", 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_held", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Release mid-stream: first edge with rst_n high captures live inputs.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("txn reset-release a=1234 b=0001 op=ADD result=%h", bus.result);
    check_outs("reset_release", 16'h1235, 1'b0, 1'b0, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.a  = vecs[i].a;
      bus.b  = vecs[i].b;
      bus.op = alu_op_t'(vecs[i].op);
      @(posedge clk);
      #1;
      $display("txn vec%0d a=%h b=%h op=%0d result=%h zero=%b carry=%b ovf=%b",
               i, vecs[i].a, vecs[i].b, vecs[i].op, bus.result, bus.zero, bus.carry, bus.overflow);
      check_outs($sformatf("vec%0d", i), vecs[i].result, vecs[i].zero,
                 vecs[i].carry, vecs[i].overflow);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    bus.a  = 16'h0000;
    bus.b  = 16'h0000;
    bus.op = ALU_OR;
    #3;
    $display("txn hold-between-edges result=%h", bus.result);
    check_outs("hold", 16'h0000, 1'b1, 1'b1, 1'b1);
    bus.a = 16'h0042;
    @(posedge clk);
    #1;
    check_outs("hold_next", 16'h0042, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with a nonzero result present.
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn reset-midcycle result=%h zero=%b", bus.result, bus.zero);
    check_outs("reset_mid", 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back sweep: op changes every cycle, checked one cycle later.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pa  = 16'($urandom);
      pb  = (i % 5 == 0) ? pa : 16'($urandom);
      pop = 3'(i % 8);
      bus.a  = pa;
      bus.b  = pb;
      bus.op = alu_op_t'(pop);
      model(pa, pb, pop, er, ez, ec, ev);
      @(posedge clk);
      #1;
      $display("txn b2b%0d a=%h b=%h op=%0d result=%h exp=%h", i, pa, pb, pop, bus.result, er);
      check_outs($sformatf("b2b%0d", i), er, ez, ec, ev);
      check($sformatf("b2b%0d.zero_consistent", i), {31'h0, bus.zero},
            {31'h0, (bus.result == 16'h0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
